// File: rtl/seq_frame_pkg.sv
// Shared constants and types for the sync/data/parity serial framer and its matching receiver.
// The receiver imports the same sync constants so both ends agree on the frame header.
package seq_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int                  SYNC_LEN     = 4;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Sync bits go out MSB first, so bit index 0 selects the pattern's top bit.
    function automatic logic sync_bit(input logic [1:0] idx);
        logic [1:0] pos;
        pos = 2'(SYNC_LEN - 1) - idx;
        return SYNC_PATTERN[pos];
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Payload handshake, bit strobe and serial outputs of the framer, bundled for port connection.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out;
    logic              frame_active;

    modport master (
        output bit_en,
        output in_valid,
        output in_data,
        input  in_ready,
        input  out,
        input  frame_active
    );

    modport slave (
        input  bit_en,
        input  in_valid,
        input  in_data,
        output in_ready,
        output out,
        output frame_active
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial framer: 1101 sync, DATA_W payload bits MSB first, even parity, then GAP_BITS idle zeros.
// The line advances one bit per bit_en strobe; the accepted payload is held in a private shift register.
module seq_frame_tx
    import seq_frame_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic          clk,
    input  logic          reset,
    seq_frame_tx_if.slave bus
);

    localparam int IDX_MAX = max_int(SYNC_LEN, DATA_W);
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
    localparam int GAP_W   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              parity_reg, parity_next;
    logic              out_reg, out_next;
    logic              active_reg, active_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            gap_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            out_reg    <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            gap_reg    <= gap_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            out_reg    <= out_next;
            active_reg <= active_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        gap_next    = gap_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        out_next    = 1'b0;
        active_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // Acceptance ignores bit_en so the first sync bit always lands one cycle later.
                if (bus.in_valid) begin
                    state_next  = SYNC;
                    idx_next    = '0;
                    gap_next    = '0;
                    shift_next  = bus.in_data;
                    parity_next = ^bus.in_data;
                end
            end
            SYNC: begin
                if (bus.bit_en) begin
                    if (idx_reg == IDX_W'(SYNC_LEN - 1)) begin
                        state_next = DATA;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.bit_en) begin
                    shift_next = shift_reg << 1;
                    if (idx_reg == IDX_W'(DATA_W - 1)) begin
                        state_next = PARITY;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bus.bit_en) begin
                    state_next = GAP;
                    gap_next   = '0;
                end
            end
            GAP: begin
                if (bus.bit_en) begin
                    if (gap_reg == GAP_W'(GAP_BITS - 1)) begin
                        state_next = IDLE;
                        gap_next   = '0;
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                gap_next   = '0;
            end
        endcase

        // The line bit is decoded from the next state so out is a plain register.
        case (state_next)
            SYNC:    out_next = sync_bit(idx_next[1:0]);
            DATA:    out_next = shift_next[DATA_W-1];
            PARITY:  out_next = parity_next;
            default: out_next = 1'b0;
        endcase
        active_next = (state_next == SYNC) || (state_next == DATA) || (state_next == PARITY);
    end

    assign bus.in_ready     = (state_reg == IDLE);
    assign bus.out          = out_reg;
    assign bus.frame_active = active_reg;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Randomised bench for seq_frame_tx against a frame-as-bit-list reference model.
// The model queues every line bit of an accepted frame and pops one per bit_en strobe.
module tb_seq_frame_tx;

    localparam int DATA_W   = 8;
    localparam int GAP_BITS = 2;
    localparam int FRAME_BITS = 4 + DATA_W + 1 + GAP_BITS;

    logic clk = 1'b0;
    logic reset;

    seq_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    seq_frame_tx #(
        .DATA_W  (DATA_W),
        .GAP_BITS(GAP_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_xfers = 0;
    bit model_q[$];

    // Expected {out, frame_active, in_ready} for the cycle currently on the line.
    function automatic logic [2:0] exp_vec();
        logic eo;
        eo = (q_size() > 0) ? model_q[0] : 1'b0;
        return {eo, (q_size() > GAP_BITS), (q_size() == 0)};
    endfunction

    function automatic int q_size();
        return model_q.size();
    endfunction

    function automatic logic [2:0] dut_vec();
        return {bus.out, bus.frame_active, bus.in_ready};
    endfunction

    // Drive one cycle of inputs, advance the model across the coming edge, wait for the next sample point.
    task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic be, input logic r);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.bit_en   = be;
        reset        = r;
        if (r) begin
            model_q.delete();
        end else if (model_q.size() == 0) begin
            if (v) begin
                model_q.push_back(1'b1);
                model_q.push_back(1'b1);
                model_q.push_back(1'b0);
                model_q.push_back(1'b1);
                for (int k = DATA_W - 1; k >= 0; k--) model_q.push_back(d[k]);
                model_q.push_back(^d);
                for (int k = 0; k < GAP_BITS; k++) model_q.push_back(1'b0);
                model_xfers++;
            end
        end else if (be) begin
            void'(model_q.pop_front());
        end
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rnd();
        return DATA_W'($urandom);
    endfunction

    task automatic test_reset();
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (bus.out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", bus.out); end
        checks++;
        if (bus.frame_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", bus.frame_active); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
        // Reset wins over a simultaneous transfer.
        tick(1'b1, 8'h3C, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== 3'b001) begin errors++; $display("FAIL reset_vs_xfer: got %b expected 001", dut_vec()); end
        tick(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== 3'b001) begin errors++; $display("FAIL reset_dropped: got %b expected 001", dut_vec()); end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_basic();
        logic [14:0] golden;
        golden = 15'b110110100101000;
        tick(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (bus.out !== golden[14-i]) begin
                errors++; $display("FAIL basic_a5 bit %0d: got %b expected %b", i, bus.out, golden[14-i]);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL basic_model bit %0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
            tick(1'b0, rnd(), 1'b1, 1'b0);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_return: got %b expected 1", bus.in_ready); end
        $display("test_basic A5 frame done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_parity();
        logic [DATA_W-1:0] vals [2];
        logic              pars [2];
        logic [14:0]       got;
        vals[0] = 8'h01; pars[0] = 1'b1;
        vals[1] = 8'h00; pars[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            got = '0;
            tick(1'b1, vals[t], 1'b1, 1'b0);
            for (int i = 0; i < 15; i++) begin
                got[14-i] = bus.out;
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++; $display("FAIL parity_model %h bit %0d: got %b expected %b", vals[t], i, dut_vec(), exp_vec());
                end
                tick(1'b0, rnd(), 1'b1, 1'b0);
            end
            checks++;
            if (got[2] !== pars[t]) begin
                errors++; $display("FAIL parity_bit %h: got %b expected %b", vals[t], got[2], pars[t]);
            end
            if (vals[t] == 8'h00) begin
                checks++;
                if (got[10:3] !== 8'h00) begin
                    errors++; $display("FAIL parity_zero_data: got %b expected 00000000", got[10:3]);
                end
            end
            $display("test_parity payload %h done: checks=%0d errors=%0d", vals[t], checks, errors);
        end
    endtask

    task automatic test_slow_bit_en();
        int active_cycles;
        active_cycles = 0;
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int c = 0; c < FRAME_BITS * 4; c++) begin
            if (bus.frame_active === 1'b1) active_cycles++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL slow_model cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
            tick(1'b0, rnd(), ((c % 4) == 3), 1'b0);
        end
        checks++;
        if (active_cycles != 52) begin
            errors++; $display("FAIL slow_active_len: got %0d cycles expected 52", active_cycles);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL slow_ready_end: got %b expected 1", bus.in_ready); end
        $display("test_slow_bit_en done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_hold_valid();
        int xfers_start, dut_frames;
        logic prev_active;
        xfers_start = model_xfers;
        dut_frames  = 0;
        prev_active = bus.frame_active;
        for (int c = 0; c < 240; c++) begin
            tick(1'b1, rnd(), 1'($urandom_range(0, 1)), 1'b0);
            if (bus.frame_active === 1'b1 && prev_active !== 1'b1) dut_frames++;
            prev_active = bus.frame_active;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL hold_model cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (dut_frames != model_xfers - xfers_start) begin
            errors++; $display("FAIL hold_frame_count: got %0d expected %0d", dut_frames, model_xfers - xfers_start);
        end
        // Drain so the next test starts idle.
        for (int c = 0; c < FRAME_BITS + 2; c++) tick(1'b0, '0, 1'b1, 1'b0);
        $display("test_hold_valid done: frames=%0d checks=%0d errors=%0d", dut_frames, checks, errors);
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        d = rnd();
        tick(1'b1, d, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, rnd(), 1'b1, 1'b0);
        checks++;
        if (bus.out !== d[DATA_W-4]) begin
            errors++; $display("FAIL mid_data3: got %b expected %b", bus.out, d[DATA_W-4]);
        end
        tick(1'b0, rnd(), 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== 3'b001) begin errors++; $display("FAIL mid_abort: got %b expected 001", dut_vec()); end
        tick(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== 3'b001) begin errors++; $display("FAIL mid_no_trailing: got %b expected 001", dut_vec()); end
        d = rnd();
        tick(1'b1, d, 1'b1, 1'b0);
        for (int i = 0; i < FRAME_BITS + 1; i++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL mid_refill bit %0d: got %b expected %b", i, dut_vec(), exp_vec());
            end
            tick(1'b0, rnd(), 1'b1, 1'b0);
        end
        $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick(($urandom_range(0, 3) == 0), rnd(), 1'($urandom_range(0, 1)), ($urandom_range(0, 90) == 0));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_model cyc %0d: got %b expected %b", c, dut_vec(), exp_vec());
            end
        end
        $display("test_random done: frames=%0d checks=%0d errors=%0d", model_xfers, checks, errors);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.bit_en   = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_slow_bit_en();
        test_hold_valid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
